// File: rtl/conv_oc_scheduler.sv
// conv_oc_scheduler
// Holds one multi-channel window and walks the output channels one at a time:
// fetch the weight set, drive the shared combinational MAC, capture its
// saturated result and hand it downstream on a valid/ready stream.
module conv_oc_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int KERNEL_SIZE  = 3,
    parameter int IN_CHANNEL   = 3,
    parameter int OUT_CHANNEL  = 4,
    parameter int OC_W         = (OUT_CHANNEL > 1) ? $clog2(OUT_CHANNEL) : 1
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       window_valid,
    output logic                                                       window_ready,
    input  logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   window_data,
    input  logic                                                       window_last,
    input  logic [OC_W:0]                                              cfg_num_oc,
    output logic                                                       weight_rd_en,
    output logic [OC_W-1:0]                                            weight_addr,
    input  logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] weight_rdata,
    output logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]   mac_window,
    output logic                                                       mac_window_valid,
    output logic [IN_CHANNEL*KERNEL_SIZE*KERNEL_SIZE*WEIGHT_WIDTH-1:0] mac_weight,
    output logic                                                       mac_weight_valid,
    input  logic [DATA_WIDTH-1:0]                                      mac_conv_out,
    input  logic                                                       mac_conv_valid,
    output logic                                                       out_valid,
    input  logic                                                       out_ready,
    output logic [DATA_WIDTH-1:0]                                      out_data,
    output logic [OC_W-1:0]                                            out_oc,
    output logic                                                       out_last,
    output logic                                                       frame_done,
    output logic                                                       busy
);

    localparam int WIN_W = IN_CHANNEL * KERNEL_SIZE * KERNEL_SIZE * DATA_WIDTH;
    localparam int WGT_W = IN_CHANNEL * KERNEL_SIZE * KERNEL_SIZE * WEIGHT_WIDTH;
    localparam logic [OC_W:0] MAX_OC = OUT_CHANNEL[OC_W:0];

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_COMP  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [OC_W-1:0]     r_oc_cnt;
    logic [OC_W-1:0]     w_next_oc_cnt;
    logic [OC_W:0]       r_n_oc;
    logic [OC_W:0]       w_cfg_n_oc;
    logic                w_accept;
    logic                w_cap_result;
    logic                w_out_hs;
    logic                w_is_last;

    logic [WIN_W-1:0]    r_window;
    logic                r_win_last;
    logic [WGT_W-1:0]    r_weight;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [OC_W-1:0]     r_out_oc;
    logic                r_out_last;
    logic                r_out_valid;
    logic                r_frame_done;
    logic                r_window_ready;
    logic                r_busy;
    logic                r_weight_rd_en;
    logic [OC_W-1:0]     r_weight_addr;
    logic                r_mac_valid;

    // Channel count for the incoming window: 0 or out-of-range means "all channels".
    always_comb begin
        w_cfg_n_oc = cfg_num_oc;
        if ((cfg_num_oc == {(OC_W+1){1'b0}}) || (cfg_num_oc > MAX_OC)) begin
            w_cfg_n_oc = MAX_OC;
        end else begin
            w_cfg_n_oc = cfg_num_oc;
        end
    end

    // The channel being computed is the final one of this window.
    assign w_is_last = ({1'b0, r_oc_cnt} == (r_n_oc - {{OC_W{1'b0}}, 1'b1}));

    // Next-state and event decode for the channel sequencer.
    always_comb begin
        w_next_state  = r_state;
        w_next_oc_cnt = r_oc_cnt;
        w_accept      = 1'b0;
        w_cap_result  = 1'b0;
        w_out_hs      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (window_valid && r_window_ready) begin
                    w_accept      = 1'b1;
                    w_next_oc_cnt = {OC_W{1'b0}};
                    w_next_state  = S_FETCH;
                end else begin
                    w_next_state  = S_IDLE;
                end
            end
            S_FETCH: w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_COMP;
            S_COMP: begin
                if (mac_conv_valid) begin
                    w_cap_result = 1'b1;
                    w_next_state = S_OUT;
                end else begin
                    w_next_state = S_COMP;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    w_out_hs = 1'b1;
                    if (r_out_last) begin
                        w_next_state = S_IDLE;
                    end else begin
                        w_next_oc_cnt = r_oc_cnt + {{(OC_W-1){1'b0}}, 1'b1};
                        w_next_state  = S_FETCH;
                    end
                end else begin
                    w_next_state = S_OUT;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State, channel counter and registered control outputs (derived from next state).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_oc_cnt       <= {OC_W{1'b0}};
            r_window_ready <= 1'b0;
            r_busy         <= 1'b0;
            r_weight_rd_en <= 1'b0;
            r_weight_addr  <= {OC_W{1'b0}};
            r_mac_valid    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_out_valid    <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_oc_cnt       <= w_next_oc_cnt;
            r_window_ready <= (w_next_state == S_IDLE);
            r_busy         <= (w_next_state != S_IDLE);
            r_weight_rd_en <= (w_next_state == S_FETCH);
            r_mac_valid    <= (w_next_state == S_COMP);
            r_frame_done   <= w_out_hs && r_out_last && r_win_last;
            if (w_next_state == S_FETCH) begin
                r_weight_addr <= w_next_oc_cnt;
            end else begin
                r_weight_addr <= r_weight_addr;
            end
            if (w_cap_result) begin
                r_out_valid <= 1'b1;
            end else if (w_out_hs) begin
                r_out_valid <= 1'b0;
            end else begin
                r_out_valid <= r_out_valid;
            end
        end
    end

    // Window, weight and result holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window   <= {WIN_W{1'b0}};
            r_win_last <= 1'b0;
            r_n_oc     <= {(OC_W+1){1'b0}};
            r_weight   <= {WGT_W{1'b0}};
            r_out_data <= {DATA_WIDTH{1'b0}};
            r_out_oc   <= {OC_W{1'b0}};
            r_out_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_window   <= window_data;
                r_win_last <= window_last;
                r_n_oc     <= w_cfg_n_oc;
            end
            if (r_state == S_LOAD) begin
                r_weight <= weight_rdata;
            end
            if (w_cap_result) begin
                r_out_data <= mac_conv_out;
                r_out_oc   <= r_oc_cnt;
                r_out_last <= w_is_last;
            end
        end
    end

    assign window_ready     = r_window_ready;
    assign busy             = r_busy;
    assign weight_rd_en     = r_weight_rd_en;
    assign weight_addr      = r_weight_addr;
    assign mac_window       = r_window;
    assign mac_weight       = r_weight;
    assign mac_window_valid = r_mac_valid;
    assign mac_weight_valid = r_mac_valid;
    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign out_oc           = r_out_oc;
    assign out_last         = r_out_last;
    assign frame_done       = r_frame_done;

endmodule

// File: tb/tb_conv_oc_scheduler.sv
// Bench for conv_oc_scheduler: models the weight memory and the MAC, and
// checks every result against sums computed straight from the stimulus.
module tb_conv_oc_scheduler;

    localparam int DW    = 8;
    localparam int WW    = 8;
    localparam int K     = 3;
    localparam int IC    = 3;
    localparam int OC    = 4;
    localparam int OC_W  = 2;
    localparam int ELEMS = IC * K * K;
    localparam int WIN_W = ELEMS * DW;
    localparam int WGT_W = ELEMS * WW;

    logic               clk;
    logic               rst;
    logic               window_valid;
    logic               window_ready;
    logic [WIN_W-1:0]   window_data;
    logic               window_last;
    logic [OC_W:0]      cfg_num_oc;
    logic               weight_rd_en;
    logic [OC_W-1:0]    weight_addr;
    logic [WGT_W-1:0]   weight_rdata;
    logic [WIN_W-1:0]   mac_window;
    logic               mac_window_valid;
    logic [WGT_W-1:0]   mac_weight;
    logic               mac_weight_valid;
    logic [DW-1:0]      mac_conv_out;
    logic               mac_conv_valid;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic [OC_W-1:0]    out_oc;
    logic               out_last;
    logic               frame_done;
    logic               busy;

    logic               mac_ok;
    logic [WGT_W-1:0]   wmem [OC];
    int                 n_checks;
    int                 n_errors;

    conv_oc_scheduler #(
        .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .KERNEL_SIZE(K),
        .IN_CHANNEL(IC), .OUT_CHANNEL(OC), .OC_W(OC_W)
    ) dut (
        .clk(clk), .rst(rst),
        .window_valid(window_valid), .window_ready(window_ready),
        .window_data(window_data), .window_last(window_last), .cfg_num_oc(cfg_num_oc),
        .weight_rd_en(weight_rd_en), .weight_addr(weight_addr), .weight_rdata(weight_rdata),
        .mac_window(mac_window), .mac_window_valid(mac_window_valid),
        .mac_weight(mac_weight), .mac_weight_valid(mac_weight_valid),
        .mac_conv_out(mac_conv_out), .mac_conv_valid(mac_conv_valid),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_oc(out_oc), .out_last(out_last), .frame_done(frame_done), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Saturated dot product of a window and a weight set.
    function automatic int ref_mac(input logic [WIN_W-1:0] w, input logic [WGT_W-1:0] k);
        int s;
        s = 0;
        for (int i = 0; i < ELEMS; i++) begin
            s += int'(w[i*DW +: DW]) * int'(k[i*WW +: WW]);
        end
        return (s > 255) ? 255 : s;
    endfunction

    function automatic logic [WIN_W-1:0] rand_win(input int maxv);
        logic [WIN_W-1:0] v;
        for (int i = 0; i < ELEMS; i++) v[i*DW +: DW] = DW'($urandom_range(0, maxv));
        return v;
    endfunction

    function automatic logic [WGT_W-1:0] rand_wgt(input int maxv);
        logic [WGT_W-1:0] v;
        for (int i = 0; i < ELEMS; i++) v[i*WW +: WW] = WW'($urandom_range(0, maxv));
        return v;
    endfunction

    // Synchronous weight memory: data valid one cycle after the read strobe,
    // otherwise scrambled so a late capture is visible.
    always @(posedge clk) begin
        if (weight_rd_en) weight_rdata <= wmem[weight_addr];
        else              weight_rdata <= ~weight_rdata;
    end

    // Combinational MAC stand-in with an optional stall.
    always_comb begin
        mac_conv_out   = DW'(ref_mac(mac_window, mac_weight));
        mac_conv_valid = mac_window_valid & mac_weight_valid & mac_ok;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sends one window and follows it to completion (or to an injected reset).
    task automatic run_window(input logic [WIN_W-1:0] win, input bit last, input int cfg,
                              input bit rnd, input int bp_oc, input int bp_len, input int abort_oc);
        int n, got, cyc, last_hs, bp_left, exp_gap;
        bit seen, hs;
        int exp_d [OC];
        logic [DW-1:0]   h_data;
        logic [OC_W-1:0] h_oc;
        logic            h_last;
        n = (cfg == 0 || cfg > OC) ? OC : cfg;
        for (int k = 0; k < OC; k++) exp_d[k] = ref_mac(win, wmem[k]);
        cyc = 0;
        while (!window_ready && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        check_eq("ready_before_accept", window_ready, 1);
        window_data  = win;
        window_last  = last;
        cfg_num_oc   = cfg[OC_W:0];
        window_valid = 1'b1;
        @(posedge clk); #1;
        window_valid = 1'b0;
        window_data  = rand_win(255);
        cfg_num_oc   = (OC_W+1)'($urandom_range(0, 7));
        check_eq("ready_low_after_accept", window_ready, 0);
        check_eq("busy_after_accept", busy, 1);
        cyc = 0; last_hs = 0; got = 0; seen = 1'b0; bp_left = 0;
        while (got < n && cyc < 500) begin
            if (abort_oc >= 0 && got == abort_oc && mac_window_valid) begin
                rst = 1'b1;
                #1;
                check_eq("abort_out_valid", out_valid, 0);
                check_eq("abort_busy", busy, 0);
                check_eq("abort_rd_en", weight_rd_en, 0);
                check_eq("abort_mac_valid", mac_window_valid, 0);
                check_eq("abort_ready", window_ready, 0);
                repeat (3) begin
                    @(posedge clk); #1;
                    check_eq("abort_no_frame_done", frame_done, 0);
                end
                rst = 1'b0; out_ready = 1'b1; mac_ok = 1'b1;
                return;
            end
            if (frame_done) check_eq("early_frame_done", frame_done, 0);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1'b1; h_data = out_data; h_oc = out_oc; h_last = out_last;
                    check_eq("out_data", out_data, exp_d[got]);
                    check_eq("out_oc", out_oc, got);
                    check_eq("out_last", out_last, (got == n - 1));
                end else begin
                    check_eq("hold_data", out_data, h_data);
                    check_eq("hold_oc", out_oc, h_oc);
                    check_eq("hold_last", out_last, h_last);
                    check_eq("hold_no_fetch", weight_rd_en, 0);
                end
            end
            if (rnd) begin
                out_ready = ($urandom_range(0, 2) != 0);
                mac_ok    = ($urandom_range(0, 3) != 0);
            end else begin
                mac_ok = 1'b1;
                if (got == bp_oc && out_valid && bp_left < bp_len) begin
                    out_ready = 1'b0; bp_left++;
                end else begin
                    out_ready = 1'b1;
                end
            end
            hs = out_valid && out_ready;
            @(posedge clk); #1; cyc++;
            if (hs) begin
                if (!rnd) begin
                    exp_gap = 4 + ((got == bp_oc) ? bp_len : 0);
                    check_eq("handshake_gap", cyc - last_hs, exp_gap);
                end
                last_hs = cyc; got++; seen = 1'b0;
                check_eq("valid_drops", out_valid, 0);
                if (got < n) begin
                    check_eq("fetch_after_hs", weight_rd_en, 1);
                    check_eq("fetch_addr", weight_addr, got);
                end else begin
                    check_eq("frame_done", frame_done, last);
                    check_eq("ready_returns", window_ready, 1);
                    check_eq("busy_clears", busy, 0);
                end
            end
        end
        check_eq("result_count", got, n);
        if (got == n) begin
            @(posedge clk); #1;
            check_eq("frame_done_one_cycle", frame_done, 0);
        end
        out_ready = 1'b1; mac_ok = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIN_W-1:0] win;
        n_checks = 0; n_errors = 0;
        rst = 1'b0; window_valid = 1'b0; window_data = '0; window_last = 1'b0;
        cfg_num_oc = '0; out_ready = 1'b1; mac_ok = 1'b1; weight_rdata = '0;
        for (int k = 0; k < OC; k++) wmem[k] = '0;
        #3 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", window_ready, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_rd_en", weight_rd_en, 0);
        check_eq("rst_addr", weight_addr, 0);
        check_eq("rst_mac_valid", {mac_window_valid, mac_weight_valid}, 0);
        check_eq("rst_mac_data", {31'd0, (|mac_window) | (|mac_weight)}, 0);
        check_eq("rst_out", {out_data, out_oc, out_last, frame_done}, 0);
        rst = 1'b0;
        #1;
        check_eq("ready_before_edge", window_ready, 0);
        @(posedge clk); #1;
        check_eq("ready_after_release", window_ready, 1);
        check_eq("idle_busy", busy, 0);

        // All-ones window, weight set k filled with k+1, all channels.
        for (int k = 0; k < OC; k++) wmem[k] = {ELEMS{WW'(k + 1)}};
        win = {ELEMS{8'd1}};
        run_window(win, 1'b0, 0, 1'b0, -1, 0, -1);

        // Saturation passthrough.
        for (int k = 0; k < OC; k++) wmem[k] = {ELEMS{8'd255}};
        run_window({ELEMS{8'd255}}, 1'b0, 4, 1'b0, -1, 0, -1);

        // Five cycles of backpressure on channel 1.
        for (int k = 0; k < OC; k++) wmem[k] = rand_wgt(3);
        run_window(rand_win(3), 1'b0, 4, 1'b0, 1, 5, -1);

        // Two channels, last window of the frame.
        run_window(rand_win(5), 1'b1, 2, 1'b0, -1, 0, -1);

        // Out-of-range channel count falls back to all channels.
        run_window(rand_win(2), 1'b1, 6, 1'b0, -1, 0, -1);

        // Reset during channel 2, then a fresh window restarts at channel 0.
        run_window(rand_win(3), 1'b1, 4, 1'b0, -1, 0, 2);
        run_window(rand_win(3), 1'b1, 3, 1'b0, -1, 0, -1);

        // Randomized windows with random stalls on both sides.
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < OC; k++) wmem[k] = rand_wgt(($urandom_range(0, 1) != 0) ? 3 : 255);
            run_window(rand_win(($urandom_range(0, 1) != 0) ? 4 : 255),
                       1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'b1, -1, 0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
